// File: rtl/constantin_pkg.sv
// Shared definitions for the constantin hub: bank geometry defaults, hub state
// encoding and the entry index assigned to each tuning constant.
package constantin_pkg;

    localparam int NUM_ENTRY_DEF = 40;
    localparam int WIDTH_DEF     = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } hub_state_e;

    // Consumers slice value[CST_x*WIDTH +: WIDTH] with these indices.
    localparam int CST_DEPTH0               = 0;
    localparam int CST_DEPTH1               = 1;
    localparam int CST_DEPTH2               = 2;
    localparam int CST_STOREBUFFERTHRESHOLD = 3;
    localparam int CST_STOREBUFFERTIMEOUT   = 4;
    localparam int CST_TP_TRIGGERTHRES      = 5;
    localparam int CST_TP_ENABLE            = 6;
    localparam int CST_PERF_TABLE_SIZE      = 7;

endpackage

// File: rtl/constantin_sweep_ctrl.sv
// Sequencer for the constantin hub: IDLE/LOAD/RUN state machine, sweep counter,
// reload handling and the hub_ready flag.
module constantin_sweep_ctrl
    import constantin_pkg::*;
#(
    parameter int NUM_ENTRY = NUM_ENTRY_DEF,
    parameter int IDX_W     = $clog2(NUM_ENTRY)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_reload,
    output logic             o_load_wr,
    output logic [IDX_W-1:0] o_load_idx,
    output logic             o_run,
    output logic             o_hub_ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRY - 1);

    hub_state_e       r_state;
    hub_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_cnt_nxt;
    logic             r_hub_ready;
    logic             w_hub_ready_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_hub_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hub_ready <= w_hub_ready_nxt;
        end
    end

    // A reload during LOAD restarts the sweep without writing on that edge.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_hub_ready_nxt = r_hub_ready;
        o_load_wr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_LOAD;
                w_cnt_nxt   = '0;
            end
            ST_LOAD: begin
                if (i_reload) begin
                    w_cnt_nxt = '0;
                end else begin
                    o_load_wr = 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        w_state_nxt     = ST_RUN;
                        w_cnt_nxt       = '0;
                        w_hub_ready_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (i_reload) begin
                    w_state_nxt     = ST_LOAD;
                    w_cnt_nxt       = '0;
                    w_hub_ready_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_cnt_nxt       = '0;
                w_hub_ready_nxt = 1'b0;
            end
        endcase
    end

    assign o_load_idx  = r_cnt;
    assign o_run       = (r_state == ST_RUN);
    assign o_hub_ready = r_hub_ready;

endmodule

// File: rtl/constantin_hub.sv
// Registered bank of constantin values, swept from the readers after reset and
// broadcast to consumers. Runtime overrides exist only with CONSTANTIN_HUB_OVERRIDE_EN.
module constantin_hub
    import constantin_pkg::*;
#(
    parameter int NUM_ENTRY = NUM_ENTRY_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int IDX_W     = $clog2(NUM_ENTRY)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_ENTRY*WIDTH-1:0] init_value,
    input  logic                       reload,
    input  logic                       ovr_valid,
    output logic                       ovr_ready,
    input  logic [IDX_W-1:0]           ovr_idx,
    input  logic [WIDTH-1:0]           ovr_data,
    output logic [NUM_ENTRY*WIDTH-1:0] value,
    output logic                       upd_valid,
    output logic [IDX_W-1:0]           upd_idx,
    output logic                       hub_ready,
    output logic                       ovr_err
);

    logic [WIDTH-1:0] r_bank [NUM_ENTRY];
    logic [WIDTH-1:0] w_init [NUM_ENTRY];
    logic             r_upd_valid;
    logic [IDX_W-1:0] r_upd_idx;
    logic             r_ovr_err;

    logic             w_load_wr;
    logic [IDX_W-1:0] w_load_idx;
    logic             w_run;
    logic             w_ovr_wr;
    logic             w_ovr_bad;
    logic [IDX_W-1:0] w_ovr_idx;
    logic [WIDTH-1:0] w_ovr_data;

    constantin_sweep_ctrl #(
        .NUM_ENTRY (NUM_ENTRY),
        .IDX_W     (IDX_W)
    ) u_sweep_ctrl (
        .clock       (clock),
        .reset       (reset),
        .i_reload    (reload),
        .o_load_wr   (w_load_wr),
        .o_load_idx  (w_load_idx),
        .o_run       (w_run),
        .o_hub_ready (hub_ready)
    );

    for (genvar k = 0; k < NUM_ENTRY; k++) begin : g_pack
        assign w_init[k]                = init_value[k*WIDTH +: WIDTH];
        assign value[k*WIDTH +: WIDTH]  = r_bank[k];
    end

`ifdef CONSTANTIN_HUB_OVERRIDE_EN
    logic w_ovr_fire;
    logic w_ovr_in_range;

    // Extra index bit keeps the range check correct when NUM_ENTRY is a power of two.
    assign ovr_ready      = w_run & ~reload;
    assign w_ovr_fire     = ovr_valid & ovr_ready;
    assign w_ovr_in_range = ({1'b0, ovr_idx} < (IDX_W+1)'(NUM_ENTRY));
    assign w_ovr_wr       = w_ovr_fire & w_ovr_in_range;
    assign w_ovr_bad      = w_ovr_fire & ~w_ovr_in_range;
    assign w_ovr_idx      = ovr_idx;
    assign w_ovr_data     = ovr_data;
`else
    logic w_unused_ovr;

    assign ovr_ready    = 1'b0;
    assign w_ovr_wr     = 1'b0;
    assign w_ovr_bad    = 1'b0;
    assign w_ovr_idx    = '0;
    assign w_ovr_data   = '0;
    assign w_unused_ovr = ^{ovr_valid, ovr_idx, ovr_data, w_run};
`endif

    // Sweep writes and overrides never coincide: overrides need RUN, sweeps need LOAD.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_ENTRY; k++) begin
                r_bank[k] <= '0;
            end
            r_upd_valid <= 1'b0;
            r_upd_idx   <= '0;
            r_ovr_err   <= 1'b0;
        end else begin
            r_upd_valid <= 1'b0;
            if (w_load_wr) begin
                r_bank[w_load_idx] <= w_init[w_load_idx];
                r_upd_valid        <= 1'b1;
                r_upd_idx          <= w_load_idx;
            end else if (w_ovr_wr) begin
                r_bank[w_ovr_idx] <= w_ovr_data;
                r_upd_valid       <= 1'b1;
                r_upd_idx         <= w_ovr_idx;
            end
            if (w_ovr_bad) begin
                r_ovr_err <= 1'b1;
            end
        end
    end

    assign upd_valid = r_upd_valid;
    assign upd_idx   = r_upd_idx;
    assign ovr_err   = r_ovr_err;

endmodule

// File: tb/tb_constantin_hub.sv
// Directed bench for constantin_hub: sweep timing, reload, mid-sweep reset and
// the override path (or its absence when CONSTANTIN_HUB_OVERRIDE_EN is undefined).
module tb_constantin_hub;

    localparam int NUM = 40;
    localparam int W   = 64;
    localparam int IW  = 6;

    logic              clock;
    logic              reset;
    logic [NUM*W-1:0]  init_value;
    logic              reload;
    logic              ovr_valid;
    logic              ovr_ready;
    logic [IW-1:0]     ovr_idx;
    logic [W-1:0]      ovr_data;
    logic [NUM*W-1:0]  value;
    logic              upd_valid;
    logic [IW-1:0]     upd_idx;
    logic              hub_ready;
    logic              ovr_err;

    int vectorCount = 0;
    int missCount   = 0;

`ifdef CONSTANTIN_HUB_OVERRIDE_EN
    localparam logic [W-1:0] VAL5_BEFORE_RELOAD = 64'hDEAD_BEEF;
    localparam logic [W-1:0] ERR_AFTER_RELOAD   = 64'd1;
`else
    localparam logic [W-1:0] VAL5_BEFORE_RELOAD = 64'h1005;
    localparam logic [W-1:0] ERR_AFTER_RELOAD   = 64'd0;
`endif

    constantin_hub dut (
        .clock      (clock),
        .reset      (reset),
        .init_value (init_value),
        .reload     (reload),
        .ovr_valid  (ovr_valid),
        .ovr_ready  (ovr_ready),
        .ovr_idx    (ovr_idx),
        .ovr_data   (ovr_data),
        .value      (value),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .hub_ready  (hub_ready),
        .ovr_err    (ovr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] entryOf(input int k);
        return value[k*W +: W];
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rl, input logic v, input logic [IW-1:0] idx,
                                 input logic [W-1:0] d);
        reload    = rl;
        ovr_valid = v;
        ovr_idx   = idx;
        ovr_data  = d;
    endtask

    // Walks one full sweep; withIdle covers the single IDLE cycle after reset release.
    task automatic checkSweep(input bit withIdle);
        if (withIdle) begin
            @(negedge clock);
            checkOutput("idleUpdValid", {63'd0, upd_valid}, 64'd0);
            checkOutput("idleReady", {63'd0, hub_ready}, 64'd0);
        end
        for (int e = 0; e < NUM; e++) begin
            @(negedge clock);
            checkOutput("sweepUpdValid", {63'd0, upd_valid}, 64'd1);
            checkOutput("sweepUpdIdx", {58'd0, upd_idx}, 64'(e));
            checkOutput("sweepReady", {63'd0, hub_ready}, (e == NUM-1) ? 64'd1 : 64'd0);
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0);
        for (int k = 0; k < NUM; k++) begin
            init_value[k*W +: W] = 64'h1000 + 64'(k);
        end
        repeat (2) @(negedge clock);

        checkOutput("rstValue0", entryOf(0), 64'd0);
        checkOutput("rstValue39", entryOf(39), 64'd0);
        checkOutput("rstUpdValid", {63'd0, upd_valid}, 64'd0);
        checkOutput("rstUpdIdx", {58'd0, upd_idx}, 64'd0);
        checkOutput("rstReady", {63'd0, hub_ready}, 64'd0);
        checkOutput("rstOvrErr", {63'd0, ovr_err}, 64'd0);
        checkOutput("rstOvrReady", {63'd0, ovr_ready}, 64'd0);

        reset = 1'b1;
        checkSweep(1'b1);
        checkOutput("loadValue0", entryOf(0), 64'h1000);
        checkOutput("loadValue5", entryOf(5), 64'h1005);
        checkOutput("loadValue39", entryOf(39), 64'h1027);
        @(negedge clock);
        checkOutput("runUpdQuiet", {63'd0, upd_valid}, 64'd0);
        checkOutput("runReadyHeld", {63'd0, hub_ready}, 64'd1);

`ifdef CONSTANTIN_HUB_OVERRIDE_EN
        applyStimulus(1'b0, 1'b1, 6'd5, 64'hDEAD_BEEF);
        #1 checkOutput("ovrReadyRun", {63'd0, ovr_ready}, 64'd1);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("ovrValue5", entryOf(5), 64'hDEAD_BEEF);
        checkOutput("ovrUpdValid", {63'd0, upd_valid}, 64'd1);
        checkOutput("ovrUpdIdx", {58'd0, upd_idx}, 64'd5);

        applyStimulus(1'b0, 1'b1, 6'd7, 64'hAAAA);
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, 6'd7, 64'hBBBB);
        checkOutput("b2bUpdIdx", {58'd0, upd_idx}, 64'd7);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("b2bUpdValid", {63'd0, upd_valid}, 64'd1);
        checkOutput("b2bLastWins", entryOf(7), 64'hBBBB);

        applyStimulus(1'b0, 1'b1, 6'd45, 64'h5555);
        #1 checkOutput("oorReady", {63'd0, ovr_ready}, 64'd1);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("oorNoUpd", {63'd0, upd_valid}, 64'd0);
        checkOutput("oorErr", {63'd0, ovr_err}, 64'd1);
        checkOutput("oorValue5", entryOf(5), 64'hDEAD_BEEF);
        checkOutput("oorValue39", entryOf(39), 64'h1027);
`else
        applyStimulus(1'b0, 1'b1, 6'd3, 64'hFFFF);
        for (int c = 0; c < 3; c++) begin
            #1 checkOutput("disOvrReady", {63'd0, ovr_ready}, 64'd0);
            @(negedge clock);
        end
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("disValue3", entryOf(3), 64'h1003);
        checkOutput("disNoUpd", {63'd0, upd_valid}, 64'd0);
        checkOutput("disOvrErr", {63'd0, ovr_err}, 64'd0);
`endif

        applyStimulus(1'b1, 1'b1, 6'd5, 64'h1234);
        #1 checkOutput("reloadOvrReady", {63'd0, ovr_ready}, 64'd0);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("reloadReadyDrop", {63'd0, hub_ready}, 64'd0);
        checkOutput("reloadOvrDropped", entryOf(5), VAL5_BEFORE_RELOAD);
        checkSweep(1'b0);
        checkOutput("reloadValue5", entryOf(5), 64'h1005);
        checkOutput("reloadValue7", entryOf(7), 64'h1007);
        checkOutput("reloadErrSticky", {63'd0, ovr_err}, ERR_AFTER_RELOAD);

        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        checkOutput("midUpdIdx", {58'd0, upd_idx}, 64'd18);
        checkOutput("midValue0", entryOf(0), 64'h1000);
        reset = 1'b0;
        #1;
        checkOutput("asyncValue0", entryOf(0), 64'd0);
        checkOutput("asyncValue18", entryOf(18), 64'd0);
        checkOutput("asyncReady", {63'd0, hub_ready}, 64'd0);
        checkOutput("asyncUpdValid", {63'd0, upd_valid}, 64'd0);
        checkOutput("asyncOvrErr", {63'd0, ovr_err}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        checkSweep(1'b1);
        checkOutput("resweepValue39", entryOf(39), 64'h1027);
        checkOutput("resweepValue18", entryOf(18), 64'h1012);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/constantin_hub.md
# constantin_hub

Sits directly downstream of the per-constant constantin readers. Collects their 64-bit initial values into a registered bank, sweeps them in one entry per cycle after reset, and then broadcasts stable values to the core's tuning consumers (prefetchers, store buffer, perf tables). Consumers see an update pulse whenever an entry changes. Optionally, it accepts runtime overrides from a debug/CSR agent.

## Interface
Parameters:
- NUM_ENTRY, 40, number of constants held.
- WIDTH, 64, bits per constant.
- IDX_W, $clog2(NUM_ENTRY), index width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- init_value  in  NUM_ENTRY*WIDTH  flat bus of reader outputs, entry k at bits [k*WIDTH +: WIDTH]; static after time 0.
- reload  in  1  single-cycle request to re-sweep init_value.
- ovr_valid  in  1  override request valid.
- ovr_ready  out  1  override accepted when high with ovr_valid.
- ovr_idx  in  IDX_W  override target entry.
- ovr_data  in  WIDTH  override value.
- value  out  NUM_ENTRY*WIDTH  registered constant bank, same packing as init_value.
- upd_valid  out  1  one-cycle pulse, an entry was written this cycle.
- upd_idx  out  IDX_W  index of the written entry.
- hub_ready  out  1  bank fully loaded; stays high until the next reload or reset.
- ovr_err  out  1  sticky flag, an out-of-range override occurred.

## Operation
- FSM states: IDLE, LOAD, RUN.
  - IDLE lasts exactly one cycle after reset release, then goes to LOAD with sweep counter = 0.
  - LOAD: each edge writes value[cnt] ← init_value[cnt] and increments cnt. After writing NUM_ENTRY-1, the FSM goes to RUN and sets hub_ready.
  - RUN: holds the bank and serves overrides.
- Reload:
  - reload in RUN goes to LOAD with cnt = 0; hub_ready drops on the same edge.
  - reload in LOAD restarts the sweep at cnt = 0.
  - reload in IDLE is ignored.
- ovr_ready = (state == RUN) & ~reload. It is combinational from state and reload only, with no path from ovr_valid.
- Override transfer (ovr_valid & ovr_ready), for ovr_idx < NUM_ENTRY: value[ovr_idx] ← ovr_data on that edge.
- Override transfer with ovr_idx ≥ NUM_ENTRY:
  - The data is dropped.
  - ovr_err is set; it is cleared only by reset.
  - No upd pulse is issued.
- upd_valid/upd_idx are registered. They are written on the same edge as the entry, for every LOAD write and every in-range override.
- Values are never narrowed or modified; the full WIDTH bits are copied.

## Timing
- Reset values: value = 0, upd_valid = 0, upd_idx = 0, hub_ready = 0, ovr_err = 0, state = IDLE, cnt = 0. ovr_ready is 0 as a consequence.
- Edge numbering is counted from reset release:
  - Edge 1: IDLE → LOAD.
  - Edges 2..NUM_ENTRY+1: write entries 0..NUM_ENTRY-1.
  - hub_ready is high after edge NUM_ENTRY+1.
- Override latency: value and the upd pulse are visible 1 cycle after transfer.
  - Back-to-back overrides are accepted every cycle.
  - Two overrides to the same index on consecutive cycles: the last one wins.
- Reset asserted mid-sweep or mid-override: all state returns to the reset values immediately (asynchronously); the sweep restarts from IDLE on release.

## Configuration
- CONSTANTIN_HUB_OVERRIDE_EN defined: override path as described.
- Macro undefined:
  - ovr_ready and ovr_err are tied 0.
  - ovr_valid, ovr_idx and ovr_data are ignored.
  - The bank changes only via the sweep.
  - The port list is unchanged.

## Structure
- constantin_pkg holds:
  - the NUM_ENTRY and WIDTH defaults;
  - the hub state enum (IDLE/LOAD/RUN);
  - per-constant index localparams (e.g. CST_DEPTH0, CST_STOREBUFFERTHRESHOLD, CST_TP_TRIGGERTHRES), which consumers use to slice value.
- One sub-module, constantin_sweep_ctrl: the FSM, sweep counter, reload handling and hub_ready. The bank, override decode and upd registers stay in the top.

## Test plan
- Reset release with init_value[k] = 64'h1000+k: upd_idx steps 0..39 on edges 2..41. hub_ready = 1 after edge 41. value[39] = 64'h1027.
- In RUN, override idx 5 with data 64'hDEAD_BEEF: next cycle value[5] = 64'hDEAD_BEEF, upd_valid = 1, upd_idx = 5.
- Override idx 45 (N = 40): accepted, bank unchanged, no upd pulse, ovr_err = 1 and it stays 1 through a later reload.
- reload together with ovr_valid in RUN, after overriding value[5]:
  - ovr_ready = 0 that cycle and hub_ready = 0 next cycle.
  - A full 40-cycle re-sweep follows, which restores value[5] = 64'h1005.
- Reset asserted at sweep edge 20: hub_ready stays 0, value = 0 immediately. After release the full sweep completes at edge 41.
- Macro undefined: ovr_valid held high with idx 3 in RUN keeps ovr_ready = 0, and value[3] stays 64'h1003.
